muldiv_unit: RTL

Iterative RV32M multiply/divide engine that sits beside the single-cycle ALU in the execute stage and services the MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU instructions. The ALU returns results combinationally; this block returns them after a fixed multi-cycle latency. It uses a start/busy/done handshake so the control path stalls the core while `busy` is high. It reports the same Z/N result flags as the ALU, so downstream flag consumers are shared.

---
 rtl/muldiv_unit.sv | 126 ++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide engine with a start/busy/done handshake.
// Fixed WIDTH+1 cycle latency; Z/N flags follow the registered Result.
module muldiv_unit #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             flush,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Result,
   output logic             Z_flag,
   output logic             N_flag
);
   localparam int unsigned CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

   state_t             state;
   logic [2:0]         op_r;
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH-1:0]   opnd;
   logic [WIDTH-1:0]   a_raw;
   logic               neg;
   logic               div0;
   logic               ovf;
   logic [CW-1:0]      cnt;

   logic               a_sgn, b_sgn, a_neg, b_neg, neg_new, ovf_new;
   logic [WIDTH-1:0]   a_abs, b_abs;
   logic [WIDTH:0]     mul_sum, div_trial;
   logic [2*WIDTH-1:0] mul_next, div_next, prod_fix;
   logic [WIDTH-1:0]   quo_fix, rem_fix, fin_res;

   always_comb begin
      a_sgn   = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
      b_sgn   = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
      a_neg   = a_sgn & A[WIDTH-1];
      b_neg   = b_sgn & B[WIDTH-1];
      a_abs   = a_neg ? -A : A;
      b_abs   = b_neg ? -B : B;
      neg_new = (op == 3'b110) ? a_neg : (a_neg ^ b_neg);
      ovf_new = ((op == 3'b100) || (op == 3'b110)) &&
                (A == {1'b1, {(WIDTH-1){1'b0}}}) && (B == '1);
   end

   // acc holds {partial product, multiplier} for MUL and {remainder, quotient} for DIV
   always_comb begin
      mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
      mul_next  = {mul_sum, acc[WIDTH-1:1]};
      div_trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opnd};
      div_next  = div_trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                   : {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
   end

   always_comb begin
      prod_fix = neg ? -acc : acc;
      quo_fix  = neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      rem_fix  = neg ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
      fin_res  = '0;
      case (op_r)
         3'b000:                 fin_res = prod_fix[WIDTH-1:0];
         3'b001, 3'b010, 3'b011: fin_res = prod_fix[2*WIDTH-1:WIDTH];
         3'b100, 3'b101:         fin_res = div0 ? '1 : (ovf ? {1'b1, {(WIDTH-1){1'b0}}} : quo_fix);
         default:                fin_res = div0 ? a_raw : (ovf ? '0 : rem_fix);
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         op_r   <= '0;
         acc    <= '0;
         opnd   <= '0;
         a_raw  <= '0;
         neg    <= 1'b0;
         div0   <= 1'b0;
         ovf    <= 1'b0;
         cnt    <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         Result <= '0;
      end else begin
         done <= 1'b0;
         if (flush) begin
            state <= IDLE;
            busy  <= 1'b0;
         end else begin
            case (state)
               IDLE: if (start) begin
                  op_r  <= op;
                  opnd  <= op[2] ? b_abs : a_abs;
                  acc   <= {{WIDTH{1'b0}}, (op[2] ? a_abs : b_abs)};
                  a_raw <= A;
                  neg   <= neg_new;
                  div0  <= (B == '0);
                  ovf   <= ovf_new;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= CALC;
               end
               CALC: begin
                  acc <= op_r[2] ? div_next : mul_next;
                  if (cnt == CW'(WIDTH-1)) state <= FIN;
                  else                     cnt   <= cnt + 1'b1;
               end
               FIN: begin
                  Result <= fin_res;
                  done   <= 1'b1;
                  busy   <= 1'b0;
                  state  <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign Z_flag = (Result == '0);
   assign N_flag = Result[WIDTH-1];

endmodule
